spi_arbiter: RTL and testbench

SPI_ARBITER -- requirements
Module: spi_arbiter

---
 rtl/spi_arbiter.sv | 137 +++++++++++++
 tb/tb_spi_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one SPI master among NUM_REQ requesters.
// Optional WAIT timeout is enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [8*NUM_REQ-1:0]       req_data,
    input  logic [2*NUM_REQ-1:0]       req_mode,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [NUM_REQ-1:0]         ack,
    output logic [7:0]                 rsp_data,
    output logic                       err,
    output logic                       spi_start,
    output logic [7:0]                 spi_data,
    output logic [1:0]                 spi_mode,
    input  logic                       spi_done,
    input  logic [7:0]                 spi_rx,
    output logic [$clog2(NUM_REQ)-1:0] slave_sel
);

    localparam int SEL_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

    state_t           state;
    state_t           state_next;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] win;
    logic             found;
    logic             expire;

    // ptr holds the index searched first, i.e. one past the last winner.
    always_comb begin : rr_search
        int idx;
        idx   = 0;
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = SEL_W'(idx);
            end
        end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state == LAUNCH) begin
            wait_cnt <= '0;
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    assign expire = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign expire = 1'b0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (found) state_next = LAUNCH;
            LAUNCH:  state_next = WAIT;
            WAIT: begin
                if (spi_done) begin
                    state_next = RESP;
                end else if (expire) begin
                    state_next = IDLE;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // spi_done takes priority over expiry when both land in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= '0;
            ack       <= '0;
            err       <= 1'b0;
            spi_start <= 1'b0;
            spi_data  <= '0;
            spi_mode  <= '0;
            rsp_data  <= '0;
            slave_sel <= '0;
            ptr       <= '0;
        end else begin
            state     <= state_next;
            ack       <= '0;
            err       <= 1'b0;
            spi_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        gnt       <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win;
                        slave_sel <= win;
                        spi_data  <= req_data[8*win +: 8];
                        spi_mode  <= req_mode[2*win +: 2];
                        spi_start <= 1'b1;
                        ptr       <= (win == SEL_W'(NUM_REQ - 1)) ? '0 : win + SEL_W'(1);
                    end
                end
                WAIT: begin
                    if (spi_done) begin
                        rsp_data <= spi_rx;
                        ack      <= gnt;
                    end else if (expire) begin
                        gnt <= '0;
                        err <= 1'b1;
                    end
                end
                RESP: begin
                    gnt <= '0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed testbench for spi_arbiter; a simple SPI slave model answers each
// spi_start with spi_done after slave_delay cycles and returns spi_data ^ 8'h99.
module tb_spi_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [7:0]  req_mode;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic [7:0]  rsp_data;
    logic        err;
    logic        spi_start;
    logic [7:0]  spi_data;
    logic [1:0]  spi_mode;
    logic        spi_done;
    logic [7:0]  spi_rx;
    logic [1:0]  slave_sel;

    logic        slave_en = 1'b0;
    int          slave_delay = 2;
    logic        slave_done = 1'b0;
    logic        man_done = 1'b0;

    int tests = 0;
    int fails = 0;
    int start_count = 0;
    int err_total = 0;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        logic [7:0]  mode;
        logic [3:0]  exp_gnt;
        logic [1:0]  exp_sel;
        logic [7:0]  exp_spi_data;
        logic [1:0]  exp_mode;
        logic [7:0]  exp_rsp;
    } vec_t;

    vec_t vecs[7];

    spi_arbiter #(
        .NUM_REQ(4),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .req_data(req_data),
        .req_mode(req_mode),
        .gnt(gnt),
        .ack(ack),
        .rsp_data(rsp_data),
        .err(err),
        .spi_start(spi_start),
        .spi_data(spi_data),
        .spi_mode(spi_mode),
        .spi_done(spi_done),
        .spi_rx(spi_rx),
        .slave_sel(slave_sel)
    );

    always #5 clk = ~clk;

    assign spi_done = slave_done | man_done;
    assign spi_rx   = spi_data ^ 8'h99;

    always begin
        @(negedge clk);
        if (slave_en && spi_start) begin
            repeat (slave_delay) @(negedge clk);
            slave_done = 1'b1;
            @(negedge clk);
            slave_done = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (spi_start) start_count++;
        if (err) err_total++;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_gnt"}, 32'(gnt), 32'h0);
        checkOutput({tag, "_ack"}, 32'(ack), 32'h0);
        checkOutput({tag, "_err"}, 32'(err), 32'h0);
        checkOutput({tag, "_start"}, 32'(spi_start), 32'h0);
        checkOutput({tag, "_spi_data"}, 32'(spi_data), 32'h0);
        checkOutput({tag, "_spi_mode"}, 32'(spi_mode), 32'h0);
        checkOutput({tag, "_rsp_data"}, 32'(rsp_data), 32'h0);
        checkOutput({tag, "_slave_sel"}, 32'(slave_sel), 32'h0);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic waitAck(output int n);
        n = 0;
        while (ack == 4'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    function automatic int idxOf(input logic [3:0] v);
        for (int i = 0; i < 4; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // One full transfer: grant one cycle after req, payload frozen after grant.
    task automatic applyStimulus(input string tag, input vec_t v);
        int n;
        @(negedge clk);
        req      = v.req;
        req_data = v.data;
        req_mode = v.mode;
        @(negedge clk);
        checkOutput({tag, "_gnt"}, 32'(gnt), 32'(v.exp_gnt));
        checkOutput({tag, "_sel"}, 32'(slave_sel), 32'(v.exp_sel));
        checkOutput({tag, "_spi_data"}, 32'(spi_data), 32'(v.exp_spi_data));
        checkOutput({tag, "_spi_mode"}, 32'(spi_mode), 32'(v.exp_mode));
        checkOutput({tag, "_start"}, 32'(spi_start), 32'h1);
        req_data = ~v.data;
        req_mode = ~v.mode;
        waitAck(n);
        checkOutput({tag, "_ack"}, 32'(ack), 32'(v.exp_gnt));
        checkOutput({tag, "_rsp"}, 32'(rsp_data), 32'(v.exp_rsp));
        checkOutput({tag, "_data_held"}, 32'(spi_data), 32'(v.exp_spi_data));
        checkOutput({tag, "_mode_held"}, 32'(spi_mode), 32'(v.exp_mode));
        checkOutput({tag, "_gnt_in_resp"}, 32'(gnt), 32'(v.exp_gnt));
        req = '0;
        @(negedge clk);
        checkOutput({tag, "_gnt_clear"}, 32'(gnt), 32'h0);
        checkOutput({tag, "_ack_pulse"}, 32'(ack), 32'h0);
    endtask

    initial begin
        int s0;
        int e0;
        int n;
        int order[$];
        logic [3:0] gnt_seen;
        logic [3:0] ack_seen;
        logic       err_seen;
        vec_t       v;

        vecs[0] = '{4'b0001, 32'h0000003C, 8'b00000000, 4'b0001, 2'd0, 8'h3C, 2'd0, 8'hA5};
        vecs[1] = '{4'b0010, 32'h00008100, 8'b00000100, 4'b0010, 2'd1, 8'h81, 2'd1, 8'h18};
        vecs[2] = '{4'b1000, 32'hFF000000, 8'b11000000, 4'b1000, 2'd3, 8'hFF, 2'd3, 8'h66};
        vecs[3] = '{4'b0100, 32'h00000000, 8'b00100000, 4'b0100, 2'd2, 8'h00, 2'd2, 8'h99};
        vecs[4] = '{4'b0110, 32'h11223344, 8'b11100100, 4'b0010, 2'd1, 8'h33, 2'd1, 8'hAA};
        vecs[5] = '{4'b1001, 32'h11223344, 8'b11100100, 4'b1000, 2'd3, 8'h11, 2'd3, 8'h88};
        vecs[6] = '{4'b0011, 32'h11223344, 8'b11100100, 4'b0001, 2'd0, 8'h44, 2'd0, 8'hDD};

        rst      = 1'b1;
        req      = '0;
        req_data = '0;
        req_mode = '0;
        slave_en = 1'b1;
        @(negedge clk);
        checkAllZero("reset");
        @(negedge clk);
        rst = 1'b0;

        s0 = start_count;
        for (int i = 0; i < 7; i++) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i]);
            if (i == 0) checkOutput("vec0_one_start", 32'(start_count - s0), 32'd1);
        end

        // All four request together: served 0,1,2,3 with one start each.
        doReset();
        s0 = start_count;
        order.delete();
        req_data = 32'h44332211;
        req_mode = 8'h00;
        req = 4'b1111;
        n = 0;
        while (order.size() < 4 && n < 100) begin
            @(negedge clk);
            n++;
            if (ack != 4'b0) begin
                order.push_back(idxOf(ack));
                req = req & ~ack;
            end
        end
        req = '0;
        repeat (2) @(negedge clk);
        checkOutput("all4_count", 32'(order.size()), 32'd4);
        for (int i = 0; i < order.size() && i < 4; i++) begin
            checkOutput($sformatf("all4_order%0d", i), 32'(order[i]), 32'(i));
        end
        checkOutput("all4_starts", 32'(start_count - s0), 32'd4);

        // Requesters 0 and 2 held continuously alternate.
        doReset();
        order.delete();
        gnt_seen = '0;
        req = 4'b0101;
        n = 0;
        while (order.size() < 4 && n < 100) begin
            @(negedge clk);
            n++;
            gnt_seen = gnt_seen | gnt;
            if (ack != 4'b0) order.push_back(idxOf(ack));
        end
        req = '0;
        repeat (2) @(negedge clk);
        checkOutput("alt_count", 32'(order.size()), 32'd4);
        for (int i = 0; i < order.size() && i < 4; i++) begin
            checkOutput($sformatf("alt_order%0d", i), 32'(order[i]), 32'((i % 2) * 2));
        end
        checkOutput("alt_no_gnt_1_3", 32'(gnt_seen & 4'b1010), 32'h0);

        // req0 drops after grant (transfer completes); req1 pulses only while busy.
        slave_delay = 4;
        req_data = 32'h0000AB12;
        @(negedge clk);
        req = 4'b0001;
        @(negedge clk);
        checkOutput("drop_gnt", 32'(gnt), 32'h1);
        req = 4'b0010;
        @(negedge clk);
        req = 4'b0000;
        waitAck(n);
        checkOutput("drop_ack", 32'(ack), 32'h1);
        checkOutput("drop_rsp", 32'(rsp_data), 32'h8B);
        gnt_seen = '0;
        repeat (6) begin
            @(negedge clk);
            gnt_seen = gnt_seen | gnt;
        end
        checkOutput("drop_no_regrant", 32'(gnt_seen), 32'h0);
        slave_delay = 2;

        // Reset while waiting for spi_done abandons the transfer.
        slave_en = 1'b0;
        @(negedge clk);
        req_data = 32'h000000C7;
        req = 4'b0001;
        n = 0;
        while (!spi_start && n < 10) begin
            @(negedge clk);
            n++;
        end
        checkOutput("rstwait_start", 32'(spi_start), 32'h1);
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        #1;
        checkAllZero("rstwait");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        e0 = err_total;
        ack_seen = '0;
        repeat (4) begin
            @(negedge clk);
            ack_seen = ack_seen | ack;
        end
        checkOutput("rstwait_no_ack", 32'(ack_seen), 32'h0);
        checkOutput("rstwait_no_err", 32'(err_total - e0), 32'h0);
        slave_en = 1'b1;
        v = '{4'b0100, 32'h005A0000, 8'h00, 4'b0100, 2'd2, 8'h5A, 2'd0, 8'hC3};
        applyStimulus("after_rst", v);

        // WAIT with no spi_done.
        slave_en = 1'b0;
        e0 = err_total;
        @(negedge clk);
        req_data = 32'h00000042;
        req = 4'b0001;
        n = 0;
        while (!spi_start && n < 10) begin
            @(negedge clk);
            n++;
        end
        checkOutput("to_start", 32'(spi_start), 32'h1);
        ack_seen = '0;
`ifdef SPI_ARB_TIMEOUT_EN
        begin
            int first_err;
            first_err = 0;
            for (int k = 1; k <= 40; k++) begin
                @(negedge clk);
                ack_seen = ack_seen | ack;
                if (err && first_err == 0) begin
                    first_err = k;
                    req = '0;
                    checkOutput("to_gnt_clear", 32'(gnt), 32'h0);
                    checkOutput("to_rsp_kept", 32'(rsp_data), 32'hC3);
                end
            end
            checkOutput("to_err_cycle", 32'(first_err), 32'd17);
            checkOutput("to_err_once", 32'(err_total - e0), 32'd1);
            checkOutput("to_no_ack", 32'(ack_seen), 32'h0);
            req = '0;
            slave_en = 1'b1;
            v = '{4'b0010, 32'h00007700, 8'h00, 4'b0010, 2'd1, 8'h77, 2'd0, 8'hEE};
            applyStimulus("to_next", v);
            // spi_done on the expiring cycle wins.
            e0 = err_total;
            slave_delay = 16;
            v = '{4'b0001, 32'h00000024, 8'h00, 4'b0001, 2'd0, 8'h24, 2'd0, 8'hBD};
            applyStimulus("tie", v);
            checkOutput("tie_no_err", 32'(err_total - e0), 32'h0);
            slave_delay = 2;
        end
`else
        repeat (40) begin
            @(negedge clk);
            ack_seen = ack_seen | ack;
        end
        checkOutput("nto_no_err", 32'(err_total - e0), 32'h0);
        checkOutput("nto_no_ack", 32'(ack_seen), 32'h0);
        checkOutput("nto_gnt_held", 32'(gnt), 32'h1);
        man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        waitAck(n);
        checkOutput("nto_ack", 32'(ack), 32'h1);
        checkOutput("nto_rsp", 32'(rsp_data), 32'hDB);
        req = '0;
        repeat (2) @(negedge clk);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
